// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the shared-adder controller: FSM state encoding and default datapath width.
package adder_ctrl_pkg;
    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;
endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);
    int unsigned    cand_s;
    logic [IDW-1:0] cand_idx_s;
    logic           found_s;

    // Scan requesters starting at ptr; the first valid one wins.
    always_comb begin
        gnt        = '0;
        gnt_idx    = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s     = (int'(ptr) + i) % NREQ;
            cand_idx_s = IDW'(cand_s);
            if (en && !found_s && req[cand_idx_s]) begin
                gnt[cand_idx_s] = 1'b1;
                gnt_idx         = cand_idx_s;
                found_s         = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/adder_structure_reg.sv
// Registered WIDTH-bit adder with carry-in and carry-out; result appears one edge after the operands.
module adder_structure_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    logic [WIDTH:0] sum_s;

    assign sum_s = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

    // Output register for sum and carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            s  <= '0;
            co <= 1'b0;
        end else begin
            s  <= sum_s[WIDTH-1:0];
            co <= sum_s[WIDTH];
        end
    end
endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one registered adder among NREQ requesters,
// returning a tagged response that is held until accepted.
module adder_share_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_ci,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_s,
    output logic                  rsp_co,
    output logic                  busy
);
    state_t          state_r;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  ptr_nxt_s;
    logic [IDW-1:0]  id_r;
    logic [IDW-1:0]  gnt_idx_s;
    logic [NREQ-1:0] gnt_s;
    logic [WIDTH-1:0] op_a_r;
    logic [WIDTH-1:0] op_b_r;
    logic             op_ci_r;
    logic [WIDTH-1:0] add_s_s;
    logic             add_co_s;
    logic             grant_en_s;
    logic             any_gnt_s;

    // A new grant may only issue when the adder slot is free or its response is leaving this cycle.
    assign grant_en_s = !rst && ((state_r == ST_IDLE) || ((state_r == ST_RESP) && rsp_ready));
    assign any_gnt_s  = |gnt_s;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .en      (grant_en_s),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    adder_structure_reg #(.WIDTH(WIDTH)) u_add (
        .clk (clk),
        .rst (rst),
        .a   (op_a_r),
        .b   (op_b_r),
        .ci  (op_ci_r),
        .s   (add_s_s),
        .co  (add_co_s)
    );

    // Pointer advances past the winner, wrapping at NREQ-1.
    always_comb begin
        if (gnt_idx_s == IDW'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = gnt_idx_s + IDW'(1);
        end
    end

    // Control FSM: one cycle in EXEC for the adder register, then hold RESP until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_gnt_s) state_r <= ST_EXEC;
                    else           state_r <= ST_IDLE;
                end
                ST_EXEC: state_r <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready) state_r <= any_gnt_s ? ST_EXEC : ST_IDLE;
                    else           state_r <= ST_RESP;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Operand, tag and pointer capture on the grant edge; held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= '0;
            id_r    <= '0;
            op_a_r  <= '0;
            op_b_r  <= '0;
            op_ci_r <= 1'b0;
        end else if (any_gnt_s) begin
            ptr_r   <= ptr_nxt_s;
            id_r    <= gnt_idx_s;
            op_a_r  <= req_a[gnt_idx_s*WIDTH +: WIDTH];
            op_b_r  <= req_b[gnt_idx_s*WIDTH +: WIDTH];
            op_ci_r <= req_ci[gnt_idx_s];
        end else begin
            ptr_r   <= ptr_r;
            id_r    <= id_r;
            op_a_r  <= op_a_r;
            op_b_r  <= op_b_r;
            op_ci_r <= op_ci_r;
        end
    end

    assign req_ready = gnt_s;
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_id    = id_r;
    assign rsp_s     = rsp_valid ? add_s_s : '0;
    assign rsp_co    = rsp_valid & add_co_s;
    assign busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Directed bench for adder_share_ctrl with a transaction-level model checked every cycle.
module tb_adder_share_ctrl;
    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ci;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_s;
    logic         rsp_co;
    logic         busy;

    int total = 0;
    int bad   = 0;

    adder_share_ctrl #(.WIDTH(32), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: outstanding response queue with due cycle, plus round-robin pointer.
    typedef struct {
        logic [1:0]  id;
        logic [31:0] s;
        logic        co;
        int          due;
    } rsp_t;

    rsp_t       mq[$];
    logic [1:0] m_ptr;
    int         cyc = 0;

    initial begin
        logic       exp_v, pend, win, found;
        logic [1:0] kk, idx;
        logic [3:0] exp_gnt;
        logic [32:0] sum;
        rsp_t       e;
        m_ptr = 2'd0;
        forever begin
            @(negedge clk);
            pend    = (mq.size() > 0);
            exp_v   = pend && (cyc >= mq[0].due);
            win     = !rst && (!pend || (exp_v && rsp_ready));
            exp_gnt = 4'd0;
            found   = 1'b0;
            kk      = 2'd0;
            if (win) begin
                for (int i = 0; i < 4; i++) begin
                    idx = m_ptr + 2'(i);
                    if (!found && req_valid[idx]) begin
                        found = 1'b1;
                        kk    = idx;
                    end
                end
            end
            if (found) exp_gnt[kk] = 1'b1;
            if (cyc >= 1) begin
                check("m_req_ready", 64'(req_ready), 64'(exp_gnt));
                check("m_rsp_valid", 64'(rsp_valid), 64'(exp_v));
                check("m_busy",      64'(busy),      64'(pend));
                check("m_rsp_s",     64'(rsp_s),     exp_v ? 64'(mq[0].s)  : 64'd0);
                check("m_rsp_co",    64'(rsp_co),    exp_v ? 64'(mq[0].co) : 64'd0);
                if (exp_v) check("m_rsp_id", 64'(rsp_id), 64'(mq[0].id));
            end
            if (rst) begin
                mq.delete();
                m_ptr = 2'd0;
            end else begin
                if (exp_v && rsp_ready) void'(mq.pop_front());
                if (found) begin
                    sum   = {1'b0, req_a[kk*32 +: 32]} + {1'b0, req_b[kk*32 +: 32]} + 33'(req_ci[kk]);
                    e.id  = kk;
                    e.s   = sum[31:0];
                    e.co  = sum[32];
                    e.due = cyc + 2;
                    mq.push_back(e);
                    m_ptr = kk + 2'd1;
                end
            end
            cyc++;
        end
    end

    task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic ci);
        req_a[k*32 +: 32] = a;
        req_b[k*32 +: 32] = b;
        req_ci[k]         = ci;
    endtask

    // Single isolated operation on requester k with hand-computed expected result.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic [31:0] es, input logic eco);
        int n;
        int lat;
        logic [3:0] onehot;
        onehot = 4'd1 << k;
        @(posedge clk); #1;
        set_op(k, a, b, ci);
        req_valid = onehot;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 4'd0 && n < 20);
        check("op_grant", 64'(req_ready), 64'(onehot));
        @(posedge clk); #1;
        req_valid = 4'd0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
        check("op_latency", 64'(lat), 64'd2);
        check("op_id", 64'(rsp_id), 64'(k));
        check("op_s",  64'(rsp_s),  64'(es));
        check("op_co", 64'(rsp_co), 64'(eco));
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int gidx[5];
        int gcyc[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int g, n;
        logic [31:0] s0;
        logic [1:0]  id0;

        rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_ci = '0;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i * 100 + 1), 32'(i * 7 + 3), i[0]);

        // Reset held with all requests pending.
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            check("rst_busy",      64'(busy),      64'd0);
            check("rst_rsp_s",     64'(rsp_s),     64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 4'd0; rsp_ready = 1'b1;

        do_op(2, 32'd5, 32'd7, 1'b1, 32'd13, 1'b0);

        // Round robin from a fresh pointer with everyone requesting.
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0; req_valid = 4'hF;
        for (int i = 0; i < 4; i++) set_op(i, 32'(i * 100 + 1), 32'(i * 7 + 3), i[0]);
        g = 0; n = 0;
        while (g < 5 && n < 40) begin
            @(negedge clk); n++;
            if (req_ready != 4'd0) begin
                gidx[g] = oh2idx(req_ready);
                gcyc[g] = n;
                g++;
            end
        end
        check("rr_count", 64'(g), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < g) begin
                check("rr_order", 64'(gidx[i]), 64'(exp_order[i]));
                if (i > 0) check("rr_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd2);
            end else begin
                check("rr_missing", 64'(i), 64'(g));
            end
        end

        // Backpressure: stall the next response for 5 cycles.
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 4'd0 && n < 20);
        check("bp_grant_seen", 64'(req_ready != 4'd0), 64'd1);
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_exec_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("bp_valid", 64'(rsp_valid), 64'd1);
        s0 = rsp_s; id0 = rsp_id;
        repeat (4) begin
            @(negedge clk);
            check("bp_no_grant", 64'(req_ready), 64'd0);
            check("bp_s_stable", 64'(rsp_s), 64'(s0));
            check("bp_id_stable", 64'(rsp_id), 64'(id0));
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 64'(req_ready != 4'd0), 64'd1);
        @(posedge clk); #1; req_valid = 4'd0;
        repeat (4) @(posedge clk);

        // Carry-out boundaries.
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        do_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1);

        // Reset while the op is in EXEC: the response must never appear.
        @(posedge clk); #1;
        req_valid = 4'b0010;
        n = 0;
        do begin @(negedge clk); n++; end while (req_ready == 4'd0 && n < 20);
        check("mid_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1; rst = 1'b1; req_valid = 4'd0;
        @(posedge clk); #1; rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("mid_no_rsp", 64'(rsp_valid), 64'd0);
            check("mid_idle", 64'(busy), 64'd0);
        end
        @(posedge clk); #1; req_valid = 4'b1010;
        @(negedge clk);
        check("mid_ptr_reset_grant", 64'(req_ready), 64'b0010);
        @(posedge clk); #1; req_valid = 4'd0;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
